// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional jump support is compiled in when MCU_JUMP_EN is defined.
module multicycle_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32,
    parameter logic [OPCODE_W-1:0] OP_RTYPE = 0,
    parameter logic [OPCODE_W-1:0] OP_LW    = 1,
    parameter logic [OPCODE_W-1:0] OP_SW    = 2,
    parameter logic [OPCODE_W-1:0] OP_BEQ   = 3,
    parameter logic [OPCODE_W-1:0] OP_ADDI  = 4,
    parameter logic [OPCODE_W-1:0] OP_J     = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          pc_src,
    output logic                rf_we,
    output logic                rf_dsel,
    output logic                mto_rfsel,
    output logic                alu_a_sel,
    output logic [1:0]          alu_b_sel,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_dbg
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        EXEC   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
`ifdef MCU_JUMP_EN
        JUMP   = 4'd12,
`endif
        TRAP   = 4'd13
    } state_t;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 1;
    localparam logic [ALUOP_W-1:0] ALU_FN  = 3;
    localparam logic [CNT_W-1:0]   CNT_ONE = 1;

    state_t           state;
    state_t           state_n;
    logic             retire;
    logic             is_lw_q;
    logic [CNT_W-1:0] retired_q;

    assign retired   = retired_q;
    assign state_dbg = state;

    // State register, retire counter and lw/sw choice latched at decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            retired_q <= '0;
            is_lw_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (retire) begin
                retired_q <= retired_q + CNT_ONE;
            end
            if (state == DECODE) begin
                is_lw_q <= (opcode == OP_LW);
            end
        end
    end

    // Next-state and Moore outputs; FETCH/BRANCH gate PC/IR writes on inputs
    always_comb begin
        state_n   = state;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        i_or_d    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        rf_we     = 1'b0;
        rf_dsel   = 1'b0;
        mto_rfsel = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 2'd0;
        alu_op    = ALU_ADD;
        illegal   = 1'b0;
        unique case (state)
            IDLE: begin
                state_n = FETCH;
            end
            FETCH: begin
                mem_req   = 1'b1;
                alu_b_sel = 2'd1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                alu_b_sel = 2'd3;
                unique case (1'b1)
                    (opcode == OP_LW),
                    (opcode == OP_SW):    state_n = MEMADR;
                    (opcode == OP_RTYPE): state_n = EXEC;
                    (opcode == OP_BEQ):   state_n = BRANCH;
                    (opcode == OP_ADDI):  state_n = ADDIEX;
`ifdef MCU_JUMP_EN
                    (opcode == OP_J):     state_n = JUMP;
`else
                    (opcode == OP_J):     state_n = TRAP;
`endif
                    default:              state_n = TRAP;
                endcase
            end
            MEMADR: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'd2;
                state_n   = is_lw_q ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    state_n = MEMWB;
                end
            end
            MEMWB: begin
                rf_we     = 1'b1;
                mto_rfsel = 1'b1;
                retire    = 1'b1;
                state_n   = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end
            end
            EXEC: begin
                alu_a_sel = 1'b1;
                alu_op    = ALU_FN;
                state_n   = ALUWB;
            end
            ALUWB: begin
                rf_we   = 1'b1;
                rf_dsel = 1'b1;
                retire  = 1'b1;
                state_n = FETCH;
            end
            BRANCH: begin
                alu_a_sel = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_we     = zero;
                retire    = 1'b1;
                state_n   = FETCH;
            end
            ADDIEX: begin
                alu_a_sel = 1'b1;
                alu_b_sel = 2'd2;
                state_n   = ADDIWB;
            end
            ADDIWB: begin
                rf_we   = 1'b1;
                retire  = 1'b1;
                state_n = FETCH;
            end
`ifdef MCU_JUMP_EN
            JUMP: begin
                pc_src  = 2'd2;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_n = FETCH;
            end
`endif
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: driver queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, i_or_d, ir_we, pc_we;
    logic [1:0]  pc_src;
    logic        rf_we, rf_dsel, mto_rfsel, alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [2:0]  alu_op;
    logic        illegal;
    logic [31:0] retired;
    logic [3:0]  state_dbg;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .i_or_d(i_or_d), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .rf_we(rf_we), .rf_dsel(rf_dsel), .mto_rfsel(mto_rfsel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .illegal(illegal), .retired(retired), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic       rf_dsel;
        logic       mto;
        logic       a;
        logic [1:0] b;
        logic [2:0] op;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [3:0]  st;
        outs_t       o;
        logic [31:0] ret;
        int          idx;
    } exp_t;

    localparam logic [3:0] S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_MADR = 3;
    localparam logic [3:0] S_MRD = 4, S_MWB = 5, S_MWR = 6, S_EXEC = 7;
    localparam logic [3:0] S_AWB = 8, S_BR = 9, S_AIEX = 10, S_AIWB = 11;
    localparam logic [3:0] S_JUMP = 12, S_TRAP = 13;

    localparam outs_t O_IDLE = '0;
    localparam outs_t O_FW   = '{mem_req: 1'b1, b: 2'd1, default: 0};
    localparam outs_t O_FGO  = '{mem_req: 1'b1, b: 2'd1, ir_we: 1'b1,
                                 pc_we: 1'b1, default: 0};
    localparam outs_t O_DEC  = '{b: 2'd3, default: 0};
    localparam outs_t O_MADR = '{a: 1'b1, b: 2'd2, default: 0};
    localparam outs_t O_MRD  = '{mem_req: 1'b1, i_or_d: 1'b1, default: 0};
    localparam outs_t O_MWB  = '{rf_we: 1'b1, mto: 1'b1, default: 0};
    localparam outs_t O_MWR  = '{mem_req: 1'b1, mem_we: 1'b1,
                                 i_or_d: 1'b1, default: 0};
    localparam outs_t O_EXEC = '{a: 1'b1, op: 3'd3, default: 0};
    localparam outs_t O_AWB  = '{rf_we: 1'b1, rf_dsel: 1'b1, default: 0};
    localparam outs_t O_BRZ  = '{a: 1'b1, op: 3'd1, pc_src: 2'd1,
                                 pc_we: 1'b1, default: 0};
    localparam outs_t O_BRN  = '{a: 1'b1, op: 3'd1, pc_src: 2'd1,
                                 default: 0};
    localparam outs_t O_AIEX = '{a: 1'b1, b: 2'd2, default: 0};
    localparam outs_t O_AIWB = '{rf_we: 1'b1, default: 0};
    localparam outs_t O_JUMP = '{pc_src: 2'd2, pc_we: 1'b1, default: 0};
    localparam outs_t O_TRAP = '{ill: 1'b1, default: 0};

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] exp_ret = '0;
    outs_t       act;

    assign act = {mem_req, mem_we, i_or_d, ir_we, pc_we, pc_src, rf_we,
                  rf_dsel, mto_rfsel, alu_a_sel, alu_b_sel, alu_op, illegal};

    // Drive inputs for one cycle and queue what the DUT must show in it.
    // rt: this cycle retires; r=0: reset is sampled at the next edge.
    task automatic step(input logic r, input logic mr, input logic z,
                        input logic [5:0] op, input logic [3:0] st,
                        input outs_t o, input logic rt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        e.st  = st;
        e.o   = o;
        e.ret = exp_ret;
        e.idx = cyc;
        q.push_back(e);
        cyc++;
        if (rt) exp_ret = exp_ret + 32'd1;
        if (!r) exp_ret = '0;
    endtask

    // Monitor: pop one expectation per cycle and compare at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests += 3;
            if (state_dbg !== e.st) begin
                fails++;
                $display("FAIL state cyc=%0d got=%0d exp=%0d",
                         e.idx, state_dbg, e.st);
            end
            if (act !== e.o) begin
                fails++;
                $display("FAIL outs cyc=%0d got=%h exp=%h",
                         e.idx, act, e.o);
            end
            if (retired !== e.ret) begin
                fails++;
                $display("FAIL retired cyc=%0d got=%0d exp=%0d",
                         e.idx, retired, e.ret);
            end
        end
    end

    initial begin
        // reset held for two edges, then IDLE -> FETCH
        step(0, 1, 0, 6'd0, S_IDLE, O_IDLE, 0);
        step(1, 1, 0, 6'd0, S_IDLE, O_IDLE, 0);
        // R-type: 4 cycles
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd0, S_DEC, O_DEC, 0);
        step(1, 1, 0, 6'h3f, S_EXEC, O_EXEC, 0);
        step(1, 1, 0, 6'h3f, S_AWB, O_AWB, 1);
        // lw with 3 wait cycles in MEMRD: 8 cycles
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd1, S_DEC, O_DEC, 0);
        step(1, 1, 0, 6'h3f, S_MADR, O_MADR, 0);
        step(1, 0, 0, 6'd2, S_MRD, O_MRD, 0);
        step(1, 0, 0, 6'd2, S_MRD, O_MRD, 0);
        step(1, 0, 0, 6'd2, S_MRD, O_MRD, 0);
        step(1, 1, 0, 6'd2, S_MRD, O_MRD, 0);
        step(1, 1, 0, 6'd2, S_MWB, O_MWB, 1);
        // sw with one fetch wait and one write wait
        step(1, 0, 0, 6'd0, S_FETCH, O_FW, 0);
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd2, S_DEC, O_DEC, 0);
        step(1, 1, 0, 6'd1, S_MADR, O_MADR, 0);
        step(1, 0, 0, 6'd1, S_MWR, O_MWR, 0);
        step(1, 1, 0, 6'd1, S_MWR, O_MWR, 1);
        // beq taken
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd3, S_DEC, O_DEC, 0);
        step(1, 1, 1, 6'd0, S_BR, O_BRZ, 1);
        // beq not taken
        step(1, 1, 1, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 1, 6'd3, S_DEC, O_DEC, 0);
        step(1, 1, 0, 6'd0, S_BR, O_BRN, 1);
        // addi
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd4, S_DEC, O_DEC, 0);
        step(1, 1, 0, 6'd0, S_AIEX, O_AIEX, 0);
        step(1, 1, 0, 6'd0, S_AIWB, O_AIWB, 1);
        // jump: executes when enabled, traps otherwise
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'd5, S_DEC, O_DEC, 0);
`ifdef MCU_JUMP_EN
        step(1, 1, 0, 6'd0, S_JUMP, O_JUMP, 1);
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        step(1, 1, 0, 6'h3f, S_DEC, O_DEC, 0);
`endif
        // trap is absorbing whatever the inputs do
        for (int i = 0; i < 10; i++) begin
            step(1, i[0], i[1], i[5:0], S_TRAP, O_TRAP, 0);
        end
        // reset clears the trap
        step(0, 1, 0, 6'd0, S_TRAP, O_TRAP, 0);
        step(1, 0, 0, 6'd0, S_IDLE, O_IDLE, 0);
        step(1, 0, 0, 6'd0, S_FETCH, O_FW, 0);
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        // reset during an MEMRD wait aborts without retiring
        step(1, 1, 0, 6'd1, S_DEC, O_DEC, 0);
        step(1, 0, 0, 6'd0, S_MADR, O_MADR, 0);
        step(0, 0, 0, 6'd0, S_MRD, O_MRD, 0);
        step(1, 1, 0, 6'd0, S_IDLE, O_IDLE, 0);
        step(1, 1, 0, 6'd0, S_FETCH, O_FGO, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
